// File: rtl/roi_pkg.sv
// Shared definitions for the ROI crop output path.
// ROI_BIT_D is the pixel width used by both the crop stage and its output buffer.
package roi_pkg;

    localparam int ROI_BIT_D = 8;

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } roi_fifo_st_e;

endpackage

// File: rtl/roi_fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
// Intended to map onto distributed RAM.
module roi_fifo_mem #(
    parameter  int DEPTH = 1024,
    parameter  int WIDTH = 9,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/roi_axis_fifo.sv
// Output buffer after the ROI crop stage: stores a flow that cannot be back-pressured
// and re-issues it as an AXI4-Stream master, truncating frames that overflow.
module roi_axis_fifo
    import roi_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int BIT_D = ROI_BIT_D,
    parameter int BIT_S = 16
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [BIT_D-1:0] s_tdata_i,
    input  logic             s_tvalid_i,
    input  logic             s_tlast_i,
    output logic [BIT_D-1:0] m_tdata_o,
    output logic             m_tvalid_o,
    output logic             m_tlast_o,
    input  logic             m_tready_i,
    output logic             ovf_o,
    output logic [BIT_S-1:0] drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_LAST_FREE = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_FULL      = (AW+1)'(DEPTH);

    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           sof;
    roi_fifo_st_e   state;
    roi_fifo_st_e   state_nxt;
    logic           push;
    logic           pop;
    logic           wr_last;
    logic           ovf_nxt;
    logic [BIT_D:0] rd_word;

    // Decisions use the registered count, so a slot freed by a pop this cycle is not reusable yet.
    always_comb begin
        push      = 1'b0;
        ovf_nxt   = 1'b0;
        wr_last   = s_tlast_i;
        state_nxt = state;
        if (s_tvalid_i) begin
            if (state == PASS) begin
                if (count < CNT_LAST_FREE) begin
                    push = 1'b1;
                end else begin
                    ovf_nxt = 1'b1;
                    // Mid-frame with one slot left: spend it on a forced tlast.
                    if (!sof && count != CNT_FULL) begin
                        push    = 1'b1;
                        wr_last = 1'b1;
                    end
                    if (!s_tlast_i) begin
                        state_nxt = DROP;
                    end
                end
            end else if (s_tlast_i) begin
                state_nxt = PASS;
            end
        end
    end

    assign pop        = m_tvalid_o && m_tready_i;
    assign m_tvalid_o = (count != '0);
    assign m_tdata_o  = m_tvalid_o ? rd_word[BIT_D-1:0] : '0;
    assign m_tlast_o  = m_tvalid_o ? rd_word[BIT_D]     : 1'b0;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            sof        <= 1'b1;
            state      <= PASS;
            ovf_o      <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            state <= state_nxt;
            ovf_o <= ovf_nxt;
            if (s_tvalid_i) begin
                sof <= s_tlast_i;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (ovf_nxt && drop_cnt_o != '1) begin
                drop_cnt_o <= drop_cnt_o + 1'b1;
            end
        end
    end

    roi_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (BIT_D + 1)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr),
        .wdata_i ({wr_last, s_tdata_i}),
        .raddr_i (rd_ptr),
        .rdata_o (rd_word)
    );

endmodule

// File: tb/tb_roi_axis_fifo.sv
// Scoreboard bench for roi_axis_fifo: directed frames push expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_roi_axis_fifo;

    localparam int DEPTH = 8;
    localparam int BIT_D = 8;
    localparam int BIT_S = 4;

    logic             clk;
    logic             arst;
    logic [BIT_D-1:0] s_tdata;
    logic             s_tvalid;
    logic             s_tlast;
    logic [BIT_D-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tready;
    logic             ovf;
    logic [BIT_S-1:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int ovf_seen = 0;

    logic [BIT_D:0] sb_q [$];
    logic           stall_prev;
    logic [BIT_D:0] held;

    roi_axis_fifo #(
        .DEPTH (DEPTH),
        .BIT_D (BIT_D),
        .BIT_S (BIT_S)
    ) dut (
        .clk_i      (clk),
        .arst_i     (arst),
        .s_tdata_i  (s_tdata),
        .s_tvalid_i (s_tvalid),
        .s_tlast_i  (s_tlast),
        .m_tdata_o  (m_tdata),
        .m_tvalid_o (m_tvalid),
        .m_tlast_o  (m_tlast),
        .m_tready_i (m_tready),
        .ovf_o      (ovf),
        .drop_cnt_o (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one sample per cycle, half a period away from the active edge.
    always @(negedge clk) begin
        if (arst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", {31'd0, m_tvalid}, 32'd1);
                chk("hold_beat", {23'd0, m_tlast, m_tdata}, {23'd0, held});
            end
            if (m_tvalid && m_tready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h expected no beat at %0t",
                             {m_tlast, m_tdata}, $time);
                end else begin
                    logic [BIT_D:0] exp_beat;
                    exp_beat = sb_q.pop_front();
                    chk("out_beat", {23'd0, m_tlast, m_tdata}, {23'd0, exp_beat});
                end
            end
            if (ovf) ovf_seen++;
            stall_prev = m_tvalid && !m_tready;
            held       = {m_tlast, m_tdata};
        end
    end

    // One input beat; wr/forced state whether the beat is expected to be stored and with forced tlast.
    task automatic beat(input logic [BIT_D-1:0] d, input logic l, input logic wr, input logic forced);
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        if (wr) sb_q.push_back({l | forced, d});
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int ovf_base;
        arst     = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_last", {31'd0, m_tlast}, 32'd0);
        chk("rst_data", {24'd0, m_tdata}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_drop_cnt", {28'd0, drop_cnt}, 32'd0);
        arst = 1'b0;
        idle(1);

        // Streaming 4x3 ROI at full rate, one-cycle latency.
        m_tready = 1'b1;
        beat(8'h10, 1'b0, 1'b1, 1'b0);
        chk("latency_valid", {31'd0, m_tvalid}, 32'd1);
        chk("latency_data", {24'd0, m_tdata}, 32'h10);
        for (int i = 1; i < 12; i++) beat(8'(8'h10 + i), i == 11, 1'b1, 1'b0);
        idle(4);
        chk("stream_drained", sb_q.size(), 32'd0);
        chk("stream_no_ovf", ovf_seen, 32'd0);

        // Back-pressure 1010 over a 10-beat frame.
        for (int i = 0; i < 10; i++) begin
            m_tready = (i % 2 == 0);
            beat(8'(8'h20 + i), i == 9, 1'b1, 1'b0);
        end
        m_tready = 1'b1;
        idle(12);
        chk("bp_drained", sb_q.size(), 32'd0);
        chk("bp_no_ovf", ovf_seen, 32'd0);

        // Truncation: 12-beat frame into an 8-deep FIFO with no drain.
        m_tready = 1'b0;
        ovf_base = ovf_seen;
        for (int i = 0; i < 12; i++) beat(8'(8'h30 + i), i == 11, i < 8, i == 7);
        idle(2);
        chk("trunc_ovf_pulses", ovf_seen - ovf_base, 32'd1);
        chk("trunc_drop_cnt", {28'd0, drop_cnt}, 32'd1);
        chk("trunc_head", {23'd0, m_tlast, m_tdata}, 32'h030);

        // Whole-frame drop while full.
        ovf_base = ovf_seen;
        for (int i = 0; i < 5; i++) beat(8'(8'h40 + i), i == 4, 1'b0, 1'b0);
        idle(2);
        chk("drop_ovf_pulses", ovf_seen - ovf_base, 32'd1);
        chk("drop_drop_cnt", {28'd0, drop_cnt}, 32'd2);
        m_tready = 1'b1;
        idle(12);
        chk("drop_drained", sb_q.size(), 32'd0);
        chk("drop_empty", {31'd0, m_tvalid}, 32'd0);
        for (int i = 0; i < 5; i++) beat(8'(8'h50 + i), i == 4, 1'b1, 1'b0);
        idle(4);
        chk("after_drop_drained", sb_q.size(), 32'd0);

        // Push and pop together at count == DEPTH-1 mid-frame still truncates.
        m_tready = 1'b0;
        ovf_base = ovf_seen;
        for (int i = 0; i < 10; i++) begin
            if (i == 7) m_tready = 1'b1;
            beat(8'(8'h60 + i), i == 9, i < 8, i == 7);
        end
        idle(12);
        chk("pushpop_ovf_pulses", ovf_seen - ovf_base, 32'd1);
        chk("pushpop_drop_cnt", {28'd0, drop_cnt}, 32'd3);
        chk("pushpop_drained", sb_q.size(), 32'd0);

        // Single-beat frames rejected while nearly full; counter must saturate.
        m_tready = 1'b0;
        for (int i = 0; i < 7; i++) beat(8'(8'h70 + i), i == 6, 1'b1, 1'b0);
        ovf_base = ovf_seen;
        for (int j = 0; j < 14; j++) beat(8'(8'h80 + j), 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("sat_ovf_pulses", ovf_seen - ovf_base, 32'd14);
        chk("sat_drop_cnt", {28'd0, drop_cnt}, 32'd15);
        m_tready = 1'b1;
        idle(10);
        chk("sat_drained", sb_q.size(), 32'd0);

        // Asynchronous reset mid-frame with 5 entries buffered.
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) beat(8'(8'h90 + i), 1'b0, 1'b1, 1'b0);
        chk("pre_reset_valid", {31'd0, m_tvalid}, 32'd1);
        #2;
        arst = 1'b1;
        sb_q.delete();
        #1;
        chk("arst_valid", {31'd0, m_tvalid}, 32'd0);
        chk("arst_drop_cnt", {28'd0, drop_cnt}, 32'd0);
        @(posedge clk);
        #1;
        arst     = 1'b0;
        m_tready = 1'b1;
        ovf_base = ovf_seen;
        for (int i = 0; i < 3; i++) beat(8'(8'hA0 + i), i == 2, 1'b1, 1'b0);
        idle(4);
        chk("post_reset_drained", sb_q.size(), 32'd0);
        chk("post_reset_no_ovf", ovf_seen - ovf_base, 32'd0);
        chk("post_reset_drop_cnt", {28'd0, drop_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
